col_fifo_param: RTL and testbench

//  Parametrised column-readout FIFO between the column hit collector and the readout arbiter.

---
 rtl/col_fifo_param.sv | 103 ++++++++++
 tb/tb_col_fifo_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/col_fifo_param.sv
// col_fifo_param: column-readout FIFO between the hit collector and the readout arbiter.
// Circular buffer with a registered read port. All-zero words are never stored, and an
// optional filter drops a word equal to the last accepted one. Flags are derived from the pointers.
// Optional feature macro: COL_FIFO_DROP_CNT_EN adds an 8-bit saturating count of full-rejects.
module col_fifo_param #(
  parameter int DW        = 28,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int DEDUP     = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk_40MHz,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow
`ifdef COL_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] last_wr;
  logic          nz, dup, acc, rej, pop;

  // Occupancy and flags come straight from the free-running pointers.
  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == DEPTH_L);
  assign empty       = (level == '0);
  assign almost_full = (level >= AF_L);

  // A duplicate drop takes priority over a full-reject so it is never reported as overflow.
  assign nz  = |wr_data;
  assign dup = (DEDUP != 0) && (wr_data == last_wr);
  assign acc = wr_en & nz & ~full & ~dup;
  assign rej = wr_en & nz & full & ~dup;
  assign pop = rd_en & ~empty;

  // Storage array: not reset, contents are only meaningful between the pointers.
  always_ff @(posedge clk_40MHz) begin
    if (acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers and last-accepted word; a reset discards everything stored.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      last_wr <= '0;
    end else begin
      if (acc) begin
        wr_ptr  <= wr_ptr + 1'b1;
        last_wr <= wr_data;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read port; zero on idle cycles so the arbiter sees "no data".
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (pop) begin
      rd_data  <= mem[rd_ptr[AW-1:0]];
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end
  end

  // Sticky overflow; a reject in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_40MHz) begin
    if (rst)          overflow <= 1'b0;
    else if (rej)     overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef COL_FIFO_DROP_CNT_EN
  // Saturating full-reject counter; a clear coinciding with a reject restarts at one.
  always_ff @(posedge clk_40MHz) begin
    if (rst)                  drop_cnt <= '0;
    else if (rej && ovf_clr)  drop_cnt <= 8'd1;
    else if (rej)             drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    else if (ovf_clr)         drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_col_fifo_param.sv
// tb_col_fifo_param: directed bench for col_fifo_param. Two instances share all inputs,
// one with duplicate filtering on and one with it off.
module tb_col_fifo_param;

  localparam int DW = 28;
  localparam int AW = 2;

  logic          clk_40MHz = 1'b0;
  logic          rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid, a_full, b_full, a_empty, b_empty;
  logic          a_af, b_af, a_ovf, b_ovf;
  logic [AW:0]   a_level, b_level;
`ifdef COL_FIFO_DROP_CNT_EN
  logic [7:0]    a_drop, b_drop;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #12.5 clk_40MHz = ~clk_40MHz;

  col_fifo_param #(.DW(DW), .DEPTH(4), .DEDUP(1)) u_a (
    .clk_40MHz(clk_40MHz), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .level(a_level), .overflow(a_ovf)
`ifdef COL_FIFO_DROP_CNT_EN
    , .drop_cnt(a_drop)
`endif
  );

  col_fifo_param #(.DW(DW), .DEPTH(4), .DEDUP(0)) u_b (
    .clk_40MHz(clk_40MHz), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .level(b_level), .overflow(b_ovf)
`ifdef COL_FIFO_DROP_CNT_EN
    , .drop_cnt(b_drop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re, input logic oc);
    wr_en = we; wr_data = wd; rd_en = re; ovf_clr = oc;
    @(posedge clk_40MHz); #1;
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [DW-1:0] exp);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk({tag, "_data"}, 32'(a_rd_data), 32'(exp));
    chk({tag, "_vld"}, 32'(a_rd_valid), 32'(exp != 0));
  endtask

  initial begin
    // reset
    rst = 1'b1;
    @(posedge clk_40MHz); @(posedge clk_40MHz); #1;
    rst = 1'b0;
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_af", 32'(a_af), 32'd0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_vld", 32'(a_rd_valid), 32'd0);
    chk("rst_data", 32'(a_rd_data), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);

    // 1: fill then drain
    cyc(1'b1, 28'h1, 1'b0, 1'b0);
    cyc(1'b1, 28'h2, 1'b0, 1'b0);
    chk("t1_af_l2", 32'(a_af), 32'd0);
    cyc(1'b1, 28'h3, 1'b0, 1'b0);
    chk("t1_af_l3", 32'(a_af), 32'd1);
    chk("t1_full_l3", 32'(a_full), 32'd0);
    cyc(1'b1, 28'h4, 1'b0, 1'b0);
    chk("t1_full", 32'(a_full), 32'd1);
    chk("t1_level", 32'(a_level), 32'd4);
    rd_chk("t1_rd1", 28'h1);
    rd_chk("t1_rd2", 28'h2);
    rd_chk("t1_rd3", 28'h3);
    rd_chk("t1_rd4", 28'h4);
    chk("t1_empty", 32'(a_empty), 32'd1);

    // 2: dedup and zero filtering
    cyc(1'b1, 28'h5, 1'b0, 1'b0);
    cyc(1'b1, 28'h5, 1'b0, 1'b0);
    cyc(1'b1, 28'h0, 1'b0, 1'b0);
    cyc(1'b1, 28'h6, 1'b0, 1'b0);
    chk("t2_a_level", 32'(a_level), 32'd2);
    chk("t2_b_level", 32'(b_level), 32'd3);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_a_rd1", 32'(a_rd_data), 32'h5);
    chk("t2_b_rd1", 32'(b_rd_data), 32'h5);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_a_rd2", 32'(a_rd_data), 32'h6);
    chk("t2_b_rd2", 32'(b_rd_data), 32'h5);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_a_rd3_vld", 32'(a_rd_valid), 32'd0);
    chk("t2_b_rd3", 32'(b_rd_data), 32'h6);
    chk("t2_b_empty", 32'(b_empty), 32'd1);

    // 3: write while full plus read
    cyc(1'b1, 28'h1, 1'b0, 1'b0);
    cyc(1'b1, 28'h2, 1'b0, 1'b0);
    cyc(1'b1, 28'h3, 1'b0, 1'b0);
    cyc(1'b1, 28'h4, 1'b0, 1'b0);
    cyc(1'b1, 28'h9, 1'b1, 1'b0);
    chk("t3_pop", 32'(a_rd_data), 32'h1);
    chk("t3_level", 32'(a_level), 32'd3);
    chk("t3_ovf", 32'(a_ovf), 32'd1);
`ifdef COL_FIFO_DROP_CNT_EN
    chk("t3_drop", 32'(a_drop), 32'd1);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(a_ovf), 32'd0);
`ifdef COL_FIFO_DROP_CNT_EN
    chk("t3_drop_clr", 32'(a_drop), 32'd0);
`endif
    cyc(1'b1, 28'h9, 1'b0, 1'b0);
    chk("t3_refull", 32'(a_full), 32'd1);
    cyc(1'b1, 28'hB, 1'b0, 1'b1);
    chk("t3_set_wins", 32'(a_ovf), 32'd1);
`ifdef COL_FIFO_DROP_CNT_EN
    chk("t3_drop_set_wins", 32'(a_drop), 32'd1);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_ovf_clr2", 32'(a_ovf), 32'd0);
    rd_chk("t3_rd2", 28'h2);
    rd_chk("t3_rd3", 28'h3);
    rd_chk("t3_rd4", 28'h4);
    rd_chk("t3_rd9", 28'h9);
    chk("t3_empty", 32'(a_empty), 32'd1);

    // 4: write + read on an empty FIFO
    cyc(1'b1, 28'hA, 1'b1, 1'b0);
    chk("t4_vld", 32'(a_rd_valid), 32'd0);
    chk("t4_level", 32'(a_level), 32'd1);
    rd_chk("t4_rdA", 28'hA);

    // 5: streaming through the pointer wrap
    cyc(1'b1, 28'h10, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      cyc(1'b1, 28'(28'h10 + k), 1'b1, 1'b0);
      chk($sformatf("t5_data%0d", k), 32'(a_rd_data), 32'(28'h10 + k - 1));
      chk($sformatf("t5_level%0d", k), 32'(a_level), 32'd1);
    end
    rd_chk("t5_last", 28'h19);
    chk("t5_ovf", 32'(a_ovf), 32'd0);
    chk("t5_empty", 32'(a_empty), 32'd1);

    // 6: reset mid-operation
    cyc(1'b1, 28'h21, 1'b0, 1'b0);
    cyc(1'b1, 28'h22, 1'b0, 1'b0);
    cyc(1'b1, 28'h23, 1'b0, 1'b0);
    cyc(1'b1, 28'h24, 1'b0, 1'b0);
    cyc(1'b1, 28'h25, 1'b1, 1'b0);
    chk("t6_pre_level", 32'(a_level), 32'd3);
    chk("t6_pre_ovf", 32'(a_ovf), 32'd1);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_level", 32'(a_level), 32'd0);
    chk("t6_empty", 32'(a_empty), 32'd1);
    chk("t6_vld", 32'(a_rd_valid), 32'd0);
    chk("t6_data", 32'(a_rd_data), 32'd0);
    chk("t6_ovf", 32'(a_ovf), 32'd0);
`ifdef COL_FIFO_DROP_CNT_EN
    chk("t6_drop", 32'(a_drop), 32'd0);
`endif
    cyc(1'b1, 28'h24, 1'b0, 1'b0);
    chk("t6_no_dedup", 32'(a_level), 32'd1);
    rd_chk("t6_rd24", 28'h24);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
